// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from NUM_REQ requesters into a single UART transmitter,
// with a sticky error flag when the transmitter never acknowledges a send strobe.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_send,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err_timeout,
  input  logic                       err_clear
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic [CNT_W-1:0] ack_cnt;

  // Walk the requesters starting just after the last winner, wrapping at NUM_REQ-1.
  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    cand   = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx_send     <= 1'b0;
      req_ready   <= '0;
      tx_data     <= 8'h00;
      grant_id    <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      ack_cnt     <= '0;
      last_grant  <= LAST_IDX;
    end else begin
      tx_send   <= 1'b0;
      req_ready <= '0;
      // A timeout set below overrides a clear issued in the same cycle.
      if (err_clear) err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_done && found) begin
            tx_data    <= req_data[{winner, 3'b000} +: 8];
            grant_id   <= winner;
            last_grant <= winner;
            tx_send    <= 1'b1;
            req_ready  <= ONE_HOT0 << winner;
            busy       <= 1'b1;
            ack_cnt    <= CNT_W'(1);
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (!tx_done) begin
            ack_cnt <= '0;
            state   <= WAIT_DONE;
          end else if (ack_cnt >= CNT_W'(ACK_TIMEOUT)) begin
            err_timeout <= 1'b1;
            ack_cnt     <= '0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requests push expected grants, a negedge monitor
// pops and compares on every tx_send; a simple transmitter model drives tx_done.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int FRAME_LEN = 3;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_send;
  logic [7:0]           tx_data;
  logic                 tx_done = 1'b1;
  logic                 busy;
  logic [1:0]           grant_id;
  logic                 err_timeout;
  logic                 err_clear = 1'b0;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   sent_count = 0;
  int   cyc = 0;
  int   frame = 0;
  int   last_rise = 0;
  bit   rise_valid = 1'b0;
  bit   tx_en = 1'b1;
  bit   check_gap = 1'b0;
  logic prev_send = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_send(tx_send), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout), .err_clear(err_clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] data);
    exp_q.push_back('{id: id, data: data});
  endtask

  task automatic apply_stimulus(input logic [NUM_REQ-1:0] valid, input logic [31:0] data);
    req_valid = valid;
    req_data  = data;
  endtask

  task automatic wait_sent(input int target, input string name);
    for (int i = 0; i < 200; i++) begin
      if (sent_count >= target) return;
      step();
    end
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: only %0d sends seen, expected %0d", name, sent_count, target);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      if (!busy && tx_done) return;
      step();
    end
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: busy=%0b tx_done=%0b, expected idle", name, busy, tx_done);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_tx_send"}, tx_send, 0);
    check_output({tag, "_req_ready"}, req_ready, 0);
    check_output({tag, "_tx_data"}, tx_data, 8'h00);
    check_output({tag, "_grant_id"}, grant_id, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_err"}, err_timeout, 0);
  endtask

  // Transmitter model: a frame starts on a send strobe and tx_done rises FRAME_LEN cycles later.
  always @(negedge clk) begin
    if (rst) begin
      tx_done = 1'b1;
      frame   = 0;
    end else if (tx_en && tx_send) begin
      tx_done = 1'b0;
      frame   = FRAME_LEN;
    end else if (frame > 0) begin
      frame--;
      if (frame == 0) begin
        tx_done    = 1'b1;
        last_rise  = cyc;
        rise_valid = 1'b1;
      end
    end
  end

  // Monitor: every send strobe must match the oldest expected grant.
  always @(negedge clk) begin
    if (!rst && tx_send) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_send: grant_id=%0d tx_data=0x%0h, expected no send", grant_id, tx_data);
      end else begin
        e = exp_q.pop_front();
        check_output("tx_data", tx_data, e.data);
        check_output("grant_id", grant_id, e.id);
        check_output("req_ready", req_ready, 32'd1 << e.id);
      end
      check_output("send_pulse_prev", prev_send, 0);
      if (check_gap && rise_valid) check_output("send_gap", cyc - last_rise, 2);
      sent_count++;
    end
    prev_send = tx_send;
  end

  initial begin
    int base;

    // Reset values appear after the first edge and hold while rst stays high.
    rst = 1'b1;
    step();
    check_reset_values("rst1");
    step();
    check_reset_values("rst2");
    rst = 1'b0;
    step();

    // Single request; data changes after the grant must not reach tx_data.
    base = sent_count;
    push_exp(2'd0, 8'hA5);
    apply_stimulus(4'b0001, 32'h0000_00A5);
    wait_sent(base + 1, "single_send");
    apply_stimulus(4'b0000, 32'hFFFF_FFFF);
    step();
    check_output("single_busy", busy, 1);
    check_output("single_hold", tx_data, 8'hA5);
    wait_idle("single_idle");
    check_output("single_hold_end", tx_data, 8'hA5);

    // Round-robin with all requesters continuously valid, starting from reset priority.
    rst = 1'b1;
    step();
    rst = 1'b0;
    rise_valid = 1'b0;
    step();
    base = sent_count;
    push_exp(2'd0, 8'h10);
    push_exp(2'd1, 8'h21);
    push_exp(2'd2, 8'h32);
    push_exp(2'd3, 8'h43);
    push_exp(2'd0, 8'h10);
    check_gap = 1'b1;
    apply_stimulus(4'b1111, 32'h4332_2110);
    wait_sent(base + 5, "rr_sends");
    apply_stimulus(4'b0000, 32'h0);
    check_gap = 1'b0;
    wait_idle("rr_idle");

    // Fairness wrap: make requester 2 the last winner, then 1011 must go 3, 0, 1.
    base = sent_count;
    push_exp(2'd2, 8'h5C);
    apply_stimulus(4'b0100, 32'h005C_0000);
    wait_sent(base + 1, "wrap_prime");
    apply_stimulus(4'b0000, 32'h0);
    wait_idle("wrap_prime_idle");
    base = sent_count;
    push_exp(2'd3, 8'hD3);
    push_exp(2'd0, 8'hA0);
    push_exp(2'd1, 8'hB1);
    apply_stimulus(4'b1011, 32'hD300_B1A0);
    wait_sent(base + 3, "wrap_sends");
    apply_stimulus(4'b0000, 32'h0);
    wait_idle("wrap_idle");

    // Timeout: transmitter never drops tx_done, so four WAIT_ACK cycles set the sticky error.
    tx_en = 1'b0;
    base = sent_count;
    push_exp(2'd2, 8'h77);
    apply_stimulus(4'b0100, 32'h0077_0000);
    wait_sent(base + 1, "to_send");
    apply_stimulus(4'b0000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("to_err_early", err_timeout, 0);
      check_output("to_busy_early", busy, 1);
    end
    step();
    check_output("to_err_set", err_timeout, 1);
    check_output("to_busy_idle", busy, 0);
    repeat (3) step();
    check_output("to_err_held", err_timeout, 1);
    check_output("to_no_retry", sent_count, base + 1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check_output("to_err_clr", err_timeout, 0);
    tx_en = 1'b1;

    // Withdrawal: requester 1 drops its request during WAIT_DONE and must not be served.
    base = sent_count;
    push_exp(2'd0, 8'h11);
    apply_stimulus(4'b0011, 32'h0000_2211);
    wait_sent(base + 1, "wd_send");
    step();
    check_output("wd_busy", busy, 1);
    apply_stimulus(4'b0000, 32'h0000_2211);
    wait_idle("wd_idle");
    repeat (8) step();
    check_output("wd_not_served", sent_count, base + 1);

    // Reset mid-frame: outputs go to reset values and requester 0 regains first priority.
    base = sent_count;
    push_exp(2'd2, 8'h66);
    apply_stimulus(4'b0100, 32'h0066_0000);
    wait_sent(base + 1, "mr_send");
    step();
    check_output("mr_busy", busy, 1);
    rst = 1'b1;
    apply_stimulus(4'b1001, 32'h3300_000F);
    push_exp(2'd0, 8'h0F);
    step();
    check_reset_values("mr_rst1");
    step();
    check_reset_values("mr_rst2");
    rst = 1'b0;
    wait_sent(base + 2, "mr_regrant");
    apply_stimulus(4'b0000, 32'h0);
    wait_idle("mr_idle");

    check_output("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte requesters, legal range 2..8.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 4, maximum WAIT_ACK cycles before timeout, legal minimum 2.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  NUM_REQ  bit i: requester i presents a byte.
REQ-006 SHALL have port req_data  input  8*NUM_REQ  requester i byte at bits [8i+7:8i].
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-hot, one-cycle pulse: byte of requester i accepted.
REQ-008 SHALL have port tx_send  output  1  send strobe to UART transmitter.
REQ-009 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-010 SHALL have port tx_done  input  1  transmitter idle flag; high when idle, low during a frame.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 SHALL have port grant_id  output  clog2(NUM_REQ)  index of the most recently granted requester.
REQ-013 SHALL have port err_timeout  output  1  sticky flag: transmitter failed to acknowledge a send.
REQ-014 SHALL have port err_clear  input  1  clears err_timeout.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_ACK and WAIT_DONE; all outputs SHALL be registered.
REQ-016 IDLE: SHALL arbitrate only when tx_done=1 and any req_valid=1; otherwise SHALL stay in IDLE with tx_send=0.
REQ-017 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ and wraps; the first requester found with valid=1 wins.
REQ-018 On a grant in cycle T, the block SHALL set tx_data to the winner's byte, grant_id and last_grant to the winner, and next state to WAIT_ACK, all at the end of T.
REQ-019 tx_send and req_ready[winner] SHALL be high for exactly cycle T+1 only.
REQ-020 tx_data SHALL stay constant from T+1 until the next grant, so the byte is held for the whole frame.
REQ-021 WAIT_ACK: SHALL go to WAIT_DONE on the first cycle with tx_done=0.
REQ-022 WAIT_ACK: if tx_done stays 1 for ACK_TIMEOUT consecutive WAIT_ACK cycles (T+1 counts as the first), SHALL set err_timeout and return to IDLE without retrying; the byte counts as consumed.
REQ-023 WAIT_DONE: SHALL return to IDLE on the first cycle with tx_done=1, with no timeout.
REQ-024 Back-to-back: if WAIT_DONE sees tx_done=1 in cycle D and requests are pending, tx_send SHALL be high again in cycle D+2.
REQ-025 A requester that drops req_valid before its grant SHALL NOT be served; req_data is sampled only in the grant cycle.
REQ-026 req_valid or req_data changes outside IDLE SHALL have no effect.
REQ-027 err_clear=1 SHALL clear err_timeout on the next edge; if a timeout and err_clear occur in the same cycle, set SHALL win.
REQ-028 busy SHALL be 1 in WAIT_ACK and WAIT_DONE and 0 in IDLE.
REQ-029 At most one req_ready bit SHALL be high in any cycle.
REQ-030 tx_send SHALL never be high while the FSM is in WAIT_DONE.

Reset
REQ-031 While rst=1 at a clock edge: state=IDLE, tx_send=0, req_ready=0, tx_data=0x00, grant_id=0, err_timeout=0, timeout counter=0, last_grant=NUM_REQ-1 (requester 0 has first priority).
REQ-032 Reset asserted mid-frame SHALL abort the transfer at the next edge with no further tx_send; the bench must reset the transmitter together with this block.
REQ-033 Outputs SHALL take their reset values from the first edge with rst=1 and hold them while rst stays high.

Verification
REQ-034 Single request: after reset, req_valid=0001, req_data[7:0]=0xA5 -> tx_send and req_ready=0001 pulse together for one cycle, tx_data=0xA5, grant_id=0, busy=1 until tx_done returns high.
REQ-035 Round-robin: all four requesters valid continuously with bytes 0x10,0x21,0x32,0x43 -> grants in order 0,1,2,3,0; each tx_send occurs 2 cycles after the prior tx_done rise.
REQ-036 Fairness wrap: last_grant=2, req_valid=1011 -> next grant=3, then 0, then 1.
REQ-037 Timeout: tx_done tied high, ACK_TIMEOUT=4, one request -> err_timeout=1 after 4 WAIT_ACK cycles, FSM back in IDLE, err_timeout held; err_clear pulse -> err_timeout=0.
REQ-038 Withdrawal and reset: req_valid dropped while the FSM is in WAIT_DONE -> that requester is not granted after the frame. Separately, rst pulsed during WAIT_DONE -> all outputs at reset values and requester 0 wins the next arbitration.
